// File: rtl/env_vca.sv
// Envelope-controlled amplifier: slew-limits the sequencer's stepwise level
// into a linear ramp, then scales each audio sample by it in a 3-stage pipeline.
module env_vca #(
  parameter int unsigned BITS      = 16,
  parameter int unsigned SLEW_STEP = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   sample_strobe,
  input  logic [BITS-1:0]        envIn,
  input  logic signed [BITS-1:0] audioIn,
  output logic signed [BITS-1:0] audioOut,
  output logic                   outValid,
  output logic [BITS-1:0]        envSmoothed
);

  localparam logic [BITS:0]   UNITY  = {2'b01, {(BITS-1){1'b0}}};
  localparam logic [BITS:0]   STEP_W = (BITS+1)'(SLEW_STEP);
  localparam logic [BITS-1:0] STEP_N = BITS'(SLEW_STEP);

  logic [BITS-1:0]          env_q, env_d;
  logic signed [BITS-1:0]   a1_q;
  logic [BITS-1:0]          e1_q;
  logic                     v1_q;
  logic signed [2*BITS:0]   p_q;
  logic                     v2_q;
  logic signed [BITS-1:0]   audio_q;
  logic                     valid_q;

  logic [BITS:0] tgt, cur, up, tgt_plus;

  // Slew step, evaluated one bit wider so neither sum can wrap.
  // NOTE: env_d gets a default before any branch so no latch is inferred.
  always_comb begin
    tgt      = ({1'b0, envIn} > UNITY) ? UNITY : {1'b0, envIn};
    cur      = {1'b0, env_q};
    up       = cur + STEP_W;
    tgt_plus = tgt + STEP_W;
    env_d    = env_q;
    if (tgt > cur) begin
      env_d = (up < tgt) ? up[BITS-1:0] : tgt[BITS-1:0];
    end else if (tgt < cur) begin
      env_d = (cur > tgt_plus) ? (env_q - STEP_N) : tgt[BITS-1:0];
    end
  end

  // NOTE: state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_q   <= '0;
      a1_q    <= '0;
      e1_q    <= '0;
      v1_q    <= 1'b0;
      p_q     <= '0;
      v2_q    <= 1'b0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      if (sample_strobe) begin
        env_q <= env_d;
        a1_q  <= audioIn;
        e1_q  <= env_d;
      end
      v1_q <= sample_strobe;
      if (v1_q) p_q <= a1_q * $signed({1'b0, e1_q});
      v2_q <= v1_q;
      // Floor-shift by BITS-1 and truncate; gain <= unity keeps it in range.
      if (v2_q) audio_q <= p_q[2*BITS-2:BITS-1];
      valid_q <= v2_q;
    end
  end

  // Top guard bits and the fractional bits fall away in the final scaling.
  logic unused_p_bits;
  assign unused_p_bits = ^{p_q[2*BITS:2*BITS-1], p_q[BITS-2:0]};

  assign audioOut    = audio_q;
  assign outValid    = valid_q;
  assign envSmoothed = env_q;

endmodule

// File: tb/tb_env_vca.sv
// Scoreboard bench for env_vca: two instances (instant and 1024 slew) share
// stimulus; a reference model predicts each output pushed into per-DUT queues.
module tb_env_vca;

  localparam int NDUT = 2;
  localparam int STEPS [NDUT] = '{32768, 1024};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        sample_strobe = 1'b0;
  logic [15:0] envIn = '0;
  logic [15:0] audioIn = '0;

  logic [15:0] out_w  [NDUT];
  logic        vld_w  [NDUT];
  logic [15:0] envs_w [NDUT];

  int checks = 0;
  int errors = 0;
  int env_m [NDUT];
  int exp_q [NDUT][$];
  logic ena_seen = 1'b0;

  always #5 clk = ~clk;

  env_vca #(.BITS(16), .SLEW_STEP(32768)) dut_fast (
    .clk(clk), .rst(rst), .ena(ena), .sample_strobe(sample_strobe),
    .envIn(envIn), .audioIn(audioIn),
    .audioOut(out_w[0]), .outValid(vld_w[0]), .envSmoothed(envs_w[0]));

  env_vca #(.BITS(16), .SLEW_STEP(1024)) dut_slow (
    .clk(clk), .rst(rst), .ena(ena), .sample_strobe(sample_strobe),
    .envIn(envIn), .audioIn(audioIn),
    .audioOut(out_w[1]), .outValid(vld_w[1]), .envSmoothed(envs_w[1]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference slew: move toward the clamped target by at most one step.
  function automatic int slew(input int cur, input int env, input int step);
    int tgt;
    tgt = (env > 32768) ? 32768 : env;
    if (tgt > cur) return (cur + step < tgt) ? cur + step : tgt;
    if (tgt < cur) return (cur - step > tgt) ? cur - step : tgt;
    return cur;
  endfunction

  function automatic int scale(input int aud, input int env);
    longint p;
    p = longint'(aud) * longint'(env);
    return int'(p >>> 15);
  endfunction

  // One clock of stimulus; inputs change 1 ns after the edge.
  task automatic step(input bit stb, input int env, input int aud);
    sample_strobe = stb;
    envIn         = 16'(env);
    audioIn       = 16'(aud);
    if (ena && stb) begin
      for (int k = 0; k < NDUT; k++) begin
        env_m[k] = slew(env_m[k], env, STEPS[k]);
        exp_q[k].push_back(scale(aud, env_m[k]));
      end
    end
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    for (int k = 0; k < NDUT; k++) check($sformatf("env_smoothed[%0d]", k), int'(envs_w[k]), env_m[k]);
  endtask

  always @(posedge clk) ena_seen <= ena;

  // Monitor: a fresh output appears only on edges where ena was high.
  always @(negedge clk) begin
    if (rst && ena_seen) begin
      for (int k = 0; k < NDUT; k++) begin
        if (vld_w[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid[%0d]: got outValid=1 with audioOut=%0d, expected no output",
                     k, $signed(out_w[k]));
          end else begin
            check($sformatf("audio_out[%0d]", k), int'($signed(out_w[k])), exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] r;
    for (int k = 0; k < NDUT; k++) env_m[k] = 0;

    #3;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_audio[%0d]", k), int'(out_w[k]), 0);
      check($sformatf("reset_valid[%0d]", k), int'(vld_w[k]), 0);
      check($sformatf("reset_env[%0d]", k), int'(envs_w[k]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0);

    // Latency and basic scaling on the instant-slew instance.
    step(1, 16384, 1000);
    check("latency_n", int'(vld_w[0]), 0);
    step(0, 16384, 0);
    check("latency_n1", int'(vld_w[0]), 0);
    step(0, 16384, 0);
    check("latency_n2", int'(vld_w[0]), 1);
    check("half_gain_pos", int'($signed(out_w[0])), 500);
    step(1, 16384, -1000);
    repeat (3) step(0, 16384, 0);
    step(1, 16384, -1);
    repeat (3) step(0, 16384, 0);

    // Slew up on the 1024-step instance: first settle it at zero.
    repeat (40) step(1, 0, 7);
    check("slow_at_zero", int'(envs_w[1]), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 16384, 300);
      check("slew_up", int'(envs_w[1]), 1024 * (i + 1));
    end
    repeat (2) begin
      step(1, 16384, 300);
      check("slew_hold", int'(envs_w[1]), 16384);
    end
    repeat (16) step(1, 1000, -200);
    check("slew_to_1000", int'(envs_w[1]), 1000);
    step(1, 0, -200);
    check("slew_down_no_underflow", int'(envs_w[1]), 0);

    // Clamp above unity; full-scale extremes.
    step(1, 65535, -32768);
    check("clamp_env", int'(envs_w[0]), 32768);
    step(1, 65535, 32767);
    repeat (4) step(0, 65535, 0);

    // Back-to-back strobes at unity.
    for (int i = 1; i <= 4; i++) step(1, 32768, 100 * i);
    repeat (4) step(0, 32768, 0);

    // Enable gap with two samples in flight.
    step(1, 32768, 111);
    step(1, 32768, 222);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 999);
      check("gap_no_valid", int'(vld_w[0]), 0);
    end
    ena = 1'b1;
    repeat (4) step(0, 32768, 0);

    // Asynchronous reset one cycle after a strobe.
    step(1, 16384, 5000);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("async_rst_audio[%0d]", k), int'(out_w[k]), 0);
      check($sformatf("async_rst_valid[%0d]", k), int'(vld_w[k]), 0);
      check($sformatf("async_rst_env[%0d]", k), int'(envs_w[k]), 0);
      exp_q[k].delete();
      env_m[k] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) step(0, 16384, 0);
    step(1, 16384, 2000);
    repeat (4) step(0, 16384, 0);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      r = 16'($urandom);
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 65535)), int'($signed(r)));
    end
    ena = 1'b1;

    repeat (10) step(0, 0, 0);
    for (int k = 0; k < NDUT; k++) check($sformatf("drain[%0d]", k), exp_q[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
